// File: rtl/bcd_serial_converter.sv
// Sequential binary-to-BCD converter (double-dabble), one bit per clock.
// Signed or unsigned per conversion; flags magnitudes that do not fit in DIGITS digits.
module bcd_serial_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [WIDTH-1:0]      numero,
    output logic                  in_ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sinal,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    mag_q, mag_d;
    logic [4*DIGITS-1:0] work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                ovf_acc_q, ovf_acc_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                sinal_q, sinal_d;
    logic                overflow_q, overflow_d;

    logic [4*DIGITS-1:0] work_adj;
    logic [4*DIGITS-1:0] shift_work;
    logic [WIDTH-1:0]    shift_mag;
    logic                shift_carry;

    always_comb begin
        work_adj = work_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (work_q[4*k +: 4] >= 4'd5) begin
                work_adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // The bit leaving the top nibble is a carry into a digit we do not have.
    always_comb begin
        {shift_carry, shift_work, shift_mag} = {work_adj, mag_q, 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        ovf_acc_d  = ovf_acc_q;
        bcd_d      = bcd_q;
        sinal_d    = sinal_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    neg_d     = signed_mode & numero[WIDTH-1];
                    mag_d     = (signed_mode & numero[WIDTH-1]) ? (~numero + WIDTH'(1)) : numero;
                    work_d    = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                work_d    = shift_work;
                mag_d     = shift_mag;
                ovf_acc_d = ovf_acc_q | shift_carry;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = DONE;
                    bcd_d      = shift_work;
                    sinal_d    = neg_q;
                    overflow_d = ovf_acc_q | shift_carry;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            ovf_acc_q  <= 1'b0;
            bcd_q      <= '0;
            sinal_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            ovf_acc_q  <= ovf_acc_d;
            bcd_q      <= bcd_d;
            sinal_q    <= sinal_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign done     = (state_q == DONE);
    assign bcd      = bcd_q;
    assign sinal    = sinal_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Bench for bcd_serial_converter: default (16/5) and small (10/3) instances share one stimulus bus,
// each checked every cycle against an arithmetic model, plus directed literal checks.
module tb_bcd_serial_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [15:0] numero;

    logic        in_ready_a, done_a, sinal_a, overflow_a;
    logic [19:0] bcd_a;
    logic        in_ready_b, done_b, sinal_b, overflow_b;
    logic [11:0] bcd_b;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bcd_serial_converter #(.WIDTH(16), .DIGITS(5)) dut_a (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .numero(numero),
        .in_ready(in_ready_a), .done(done_a), .bcd(bcd_a), .sinal(sinal_a), .overflow(overflow_a)
    );

    bcd_serial_converter #(.WIDTH(10), .DIGITS(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .numero(numero[9:0]),
        .in_ready(in_ready_b), .done(done_b), .bcd(bcd_b), .sinal(sinal_b), .overflow(overflow_b)
    );

    typedef struct {
        int          width;
        int          digits;
        bit          busy;
        int          cyc;
        logic [39:0] pend_bcd;
        bit          pend_neg;
        bit          pend_ovf;
        logic [39:0] bcd;
        bit          neg;
        bit          ovf;
    } model_t;

    model_t m_a, m_b;
    bit     model_valid = 1'b0;

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Plain decimal arithmetic: magnitude, sign, digits modulo 10^digits, overflow.
    function automatic void convert(input logic [31:0] num, input bit sm, input int width,
                                    input int digits, output logic [39:0] b, output bit n,
                                    output bit o);
        longint mag, p, r;
        mag = longint'(num) & ((64'sd1 <<< width) - 1);
        n   = sm && num[width-1];
        if (n) mag = (64'sd1 <<< width) - mag;
        p = 1;
        for (int k = 0; k < digits; k++) p = p * 10;
        o = (mag >= p);
        r = mag % p;
        b = '0;
        for (int k = 0; k < digits; k++) begin
            b[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endfunction

    function automatic model_t modelStep(input model_t m, input bit r, input bit st,
                                         input bit sm, input logic [31:0] num);
        if (r) begin
            m.busy = 0; m.cyc = 0; m.bcd = '0; m.neg = 0; m.ovf = 0;
        end else if (!m.busy) begin
            if (st) begin
                m.busy = 1;
                m.cyc  = 0;
                convert(num, sm, m.width, m.digits, m.pend_bcd, m.pend_neg, m.pend_ovf);
            end
        end else begin
            m.cyc++;
            if (m.cyc == m.width) begin
                m.bcd = m.pend_bcd; m.neg = m.pend_neg; m.ovf = m.pend_ovf;
            end else if (m.cyc == m.width + 1) begin
                m.busy = 0;
            end
        end
        return m;
    endfunction

    always @(posedge clk) begin
        m_a.width = 16; m_a.digits = 5;
        m_b.width = 10; m_b.digits = 3;
        m_a = modelStep(m_a, rst, start, signed_mode, {16'b0, numero});
        m_b = modelStep(m_b, rst, start, signed_mode, {22'b0, numero[9:0]});
        if (rst) model_valid = 1'b1;
    end

    task automatic checkOutput(input string tag, input model_t m, input logic rdy, input logic dn,
                               input logic [39:0] b, input logic s, input logic o);
        compare({tag, ".in_ready"}, 64'(rdy), 64'(!m.busy));
        compare({tag, ".done"},     64'(dn),  64'(m.busy && m.cyc == m.width));
        compare({tag, ".bcd"},      64'(b),   64'(m.bcd));
        compare({tag, ".sinal"},    64'(s),   64'(m.neg));
        compare({tag, ".overflow"}, 64'(o),   64'(m.ovf));
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("a", m_a, in_ready_a, done_a, 40'(bcd_a), sinal_a, overflow_a);
            checkOutput("b", m_b, in_ready_b, done_b, 40'(bcd_b), sinal_b, overflow_b);
        end
    end

    task automatic waitBothReady();
        int n = 0;
        @(negedge clk);
        while (!(in_ready_a && in_ready_b) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) compare("ready_timeout", 64'(n), 64'(0));
    endtask

    // Hand-computed literals pin the model: one conversion, latency and result of one instance.
    task automatic applyStimulus(input string name, input logic [15:0] num, input bit sm,
                                 input bit use_b, input logic [19:0] exp_bcd, input bit exp_neg,
                                 input bit exp_ovf, input int exp_lat);
        int lat;
        waitBothReady();
        numero = num; signed_mode = sm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!(use_b ? done_b : done_a) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        compare({name, ".latency"}, 64'(lat), 64'(exp_lat));
        compare({name, ".bcd"}, use_b ? 64'(bcd_b) : 64'(bcd_a), 64'(exp_bcd));
        compare({name, ".sinal"}, use_b ? 64'(sinal_b) : 64'(sinal_a), 64'(exp_neg));
        compare({name, ".overflow"}, use_b ? 64'(overflow_b) : 64'(overflow_a), 64'(exp_ovf));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; numero = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compare("reset.in_ready", 64'(in_ready_a), 64'(1));
        compare("reset.bcd", 64'(bcd_a), 64'(0));
        compare("reset.done", 64'(done_a), 64'(0));

        applyStimulus("u12345",  16'd12345, 1'b0, 1'b0, 20'h12345, 1'b0, 1'b0, 17);
        applyStimulus("s_m1",    16'hFFFF,  1'b1, 1'b0, 20'h00001, 1'b1, 1'b0, 17);
        applyStimulus("u_ffff",  16'hFFFF,  1'b0, 1'b0, 20'h65535, 1'b0, 1'b0, 17);
        applyStimulus("s_min",   16'h8000,  1'b1, 1'b0, 20'h32768, 1'b1, 1'b0, 17);
        applyStimulus("s_zero",  16'h0000,  1'b1, 1'b0, 20'h00000, 1'b0, 1'b0, 17);
        applyStimulus("b_1023",  16'd1023,  1'b0, 1'b1, 20'h00023, 1'b0, 1'b1, 11);
        applyStimulus("b_999",   16'd999,   1'b0, 1'b1, 20'h00999, 1'b0, 1'b0, 11);
        applyStimulus("b_m512",  16'h0200,  1'b1, 1'b1, 20'h00512, 1'b1, 1'b0, 11);

        // start held high: only IDLE-cycle operands convert, results 18 cycles apart.
        begin
            int prev = -1;
            waitBothReady();
            start = 1'b1;
            signed_mode = 1'b0;
            for (int c = 0; c < 80; c++) begin
                numero = 16'($urandom);
                signed_mode = 1'($urandom);
                @(negedge clk);
                if (done_a) begin
                    if (prev >= 0) compare("held.gap", 64'(c - prev), 64'(18));
                    prev = c;
                end
            end
            start = 1'b0;
        end

        // Reset five cycles into a conversion aborts it.
        waitBothReady();
        numero = 16'd12345; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compare("abort.in_ready", 64'(in_ready_a), 64'(1));
        compare("abort.bcd", 64'(bcd_a), 64'(0));
        compare("abort.sinal", 64'(sinal_a), 64'(0));
        applyStimulus("after_abort", 16'd4321, 1'b0, 1'b0, 20'h04321, 1'b0, 1'b0, 17);

        // Random operands, modes, gaps and start-hold lengths.
        for (int t = 0; t < 150; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start = 1'b1;
            repeat ($urandom_range(1, 25)) begin
                case ($urandom % 6)
                    0:       numero = 16'h0000;
                    1:       numero = 16'hFFFF;
                    2:       numero = 16'h8000;
                    3:       numero = 16'h7FFF;
                    default: numero = 16'($urandom);
                endcase
                signed_mode = 1'($urandom);
                @(negedge clk);
            end
            start = 1'b0;
        end

        repeat (40) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
